// File: rtl/srv_line_mem.sv
// Cache-line backing memory model: fetches one line word-by-word from a combinational array
// (linear or critical-word-first order) and returns it with a single pulse a fixed latency after accept.
module srv_line_mem #(
  parameter int LINE_W    = 128,
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DELAY = 10,
  parameter int WRAP_EN   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_req_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  output logic              ext_gnt_o,
  output logic              ext_busy_o,
  output logic              ext_rsp_o,
  output logic [LINE_W-1:0] ext_data_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [WORD_W-1:0] rom_data_i
);

  localparam int RD_NUM = LINE_W / WORD_W;
  localparam int OFF_W  = $clog2(RD_NUM);
  localparam int CNT_W  = $clog2(MEM_DELAY + 1);

  // The delay counter reads j-1 in cycle Tj, so this value marks the cycle just before RESP.
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(MEM_DELAY - 2);
  localparam logic [CNT_W-1:0] DLY_MAX  = CNT_W'(MEM_DELAY);
  localparam logic [OFF_W-1:0] RD_LAST  = OFF_W'(RD_NUM - 1);

  generate
    if (RD_NUM < 2 || (RD_NUM & (RD_NUM - 1)) != 0 || RD_NUM * WORD_W != LINE_W) begin : g_bad_ratio
      $error("srv_line_mem: LINE_W/WORD_W must be a power of two and at least 2");
    end
    if (MEM_DELAY < RD_NUM + 1) begin : g_bad_delay
      $error("srv_line_mem: MEM_DELAY must be at least LINE_W/WORD_W + 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                    state_reg, state_next;
  logic [ADDR_W-OFF_W-1:0]   base_hi_reg;
  logic [OFF_W-1:0]          start_reg;
  logic [OFF_W-1:0]          rd_cnt_reg;
  logic [CNT_W-1:0]          dly_reg;
  logic [OFF_W-1:0]          slot;
  logic [OFF_W-1:0]          start_next;
  logic                      fill_we;

  assign slot       = start_reg + rd_cnt_reg;
  assign start_next = (WRAP_EN != 0) ? ext_addr_i[OFF_W-1:0] : '0;
  assign ext_gnt_o  = ext_req_i & ~ext_busy_o & ~rst;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (ext_gnt_o) state_next = ST_FILL;
      ST_FILL: begin
        if (rd_cnt_reg == RD_LAST) begin
          state_next = (dly_reg == DLY_LAST) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: if (dly_reg == DLY_LAST) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ext_busy_o = (state_reg != ST_IDLE);
    ext_rsp_o  = (state_reg == ST_RESP);
    fill_we    = (state_reg == ST_FILL);
    if (rst) begin
      rom_addr_o = '0;
    end else if (state_reg == ST_FILL) begin
      rom_addr_o = {base_hi_reg, slot};
    end else begin
      rom_addr_o = {ext_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_hi_reg <= '0;
      start_reg   <= '0;
      rd_cnt_reg  <= '0;
      dly_reg     <= '0;
    end else if (ext_gnt_o) begin
      base_hi_reg <= ext_addr_i[ADDR_W-1:OFF_W];
      start_reg   <= start_next;
      rd_cnt_reg  <= '0;
      dly_reg     <= '0;
    end else begin
      if (fill_we) begin
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
      end
      if (state_reg != ST_IDLE && dly_reg != DLY_MAX) begin
        dly_reg <= dly_reg + 1'b1;
      end
    end
  end

  // One register per slot; untouched slots keep the previous line's word.
  generate
    for (genvar gi = 0; gi < RD_NUM; gi++) begin : g_slot
      logic [WORD_W-1:0] word_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_reg <= '0;
        end else if (fill_we && slot == OFF_W'(gi)) begin
          word_reg <= rom_data_i;
        end
      end

      assign ext_data_o[gi*WORD_W +: WORD_W] = word_reg;
    end
  endgenerate

endmodule

// File: tb/tb_srv_line_mem.sv
// Bench for srv_line_mem: a linear and a wrap instance share stimulus; directed tables and
// corner sequences plus a timestamp-based reference model checked every cycle under random traffic.
module tb_srv_line_mem;

  localparam int MD     = 10;
  localparam int RD_NUM = 4;
  localparam logic [127:0] LINE40 = 128'hA5A50043_A5A50042_A5A50041_A5A50040;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic [31:0]       addr = '0;
  logic [1:0]        gnt, busy, rsp;
  logic [1:0][127:0] data;
  logic [1:0][31:0]  rom_addr, rom_data;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  srv_line_mem #(.WRAP_EN(0)) u_lin (
    .clk(clk), .rst(rst), .ext_req_i(req), .ext_addr_i(addr),
    .ext_gnt_o(gnt[0]), .ext_busy_o(busy[0]), .ext_rsp_o(rsp[0]), .ext_data_o(data[0]),
    .rom_addr_o(rom_addr[0]), .rom_data_i(rom_data[0])
  );

  srv_line_mem #(.WRAP_EN(1)) u_wrap (
    .clk(clk), .rst(rst), .ext_req_i(req), .ext_addr_i(addr),
    .ext_gnt_o(gnt[1]), .ext_busy_o(busy[1]), .ext_rsp_o(rsp[1]), .ext_data_o(data[1]),
    .rom_addr_o(rom_addr[1]), .rom_data_i(rom_data[1])
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction

  assign rom_data[0] = rom_word(rom_addr[0]);
  assign rom_data[1] = rom_word(rom_addr[1]);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each transaction is a timestamp; outputs follow from the cycle distance d.
  int          m_acc[2] = '{-1, -1};
  logic [31:0] m_base[2] = '{32'h0, 32'h0};
  int          m_start[2] = '{0, 0};
  logic [31:0] m_line[2][RD_NUM] = '{default: '0};
  int          cyc = 0;

  always @(negedge clk) begin
    int          d, slot;
    logic        eb, er, eg;
    logic [31:0] ea;
    logic [127:0] el;
    for (int m = 0; m < 2; m++) begin
      d = (m_acc[m] >= 0) ? cyc - m_acc[m] : -1;
      for (int k = 0; k < RD_NUM; k++) el[k*32 +: 32] = m_line[m][k];
      if (rst) begin
        eb = 1'b0; er = 1'b0; eg = 1'b0; ea = '0; el = '0;
      end else begin
        eb = (d >= 1 && d <= MD);
        er = (d == MD);
        eg = req && !eb;
        if (d >= 1 && d <= RD_NUM) ea = m_base[m] + 32'((m_start[m] + d - 1) % RD_NUM);
        else                       ea = {addr[31:2], 2'b00};
      end
      chk($sformatf("model%0d gnt cyc%0d", m, cyc), 128'(gnt[m]), 128'(eg));
      chk($sformatf("model%0d busy cyc%0d", m, cyc), 128'(busy[m]), 128'(eb));
      chk($sformatf("model%0d rsp cyc%0d", m, cyc), 128'(rsp[m]), 128'(er));
      chk($sformatf("model%0d rom_addr cyc%0d", m, cyc), 128'(rom_addr[m]), 128'(ea));
      chk($sformatf("model%0d data cyc%0d", m, cyc), data[m], el);
      if (er) $display("txn inst=%0d base=%h line=%h", m, m_base[m], data[m]);
      if (rst) begin
        m_acc[m] = -1;
        for (int k = 0; k < RD_NUM; k++) m_line[m][k] = '0;
      end else if (eg) begin
        m_acc[m]   = cyc;
        m_base[m]  = {addr[31:2], 2'b00};
        m_start[m] = (m == 1) ? int'(addr[1:0]) : 0;
      end else if (d >= 1 && d <= RD_NUM) begin
        slot = (m_start[m] + d - 1) % RD_NUM;
        m_line[m][slot] = rom_word(m_base[m] + 32'(slot));
      end
    end
    cyc++;
  end

  typedef struct {
    bit          gnt;
    bit          busy;
    bit          rsp;
    logic [31:0] ra_lin;
    logic [31:0] ra_wrap;
  } vec_t;

  vec_t tv[13];
  int   n;

  initial begin
    tv[0]  = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h40};
    tv[1]  = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h42};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 32'h41, 32'h43};
    tv[3]  = '{1'b0, 1'b1, 1'b0, 32'h42, 32'h40};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 32'h43, 32'h41};
    tv[5]  = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h40};
    tv[6]  = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h40};
    tv[7]  = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h40};
    tv[8]  = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h40};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h40};
    tv[10] = '{1'b0, 1'b1, 1'b1, 32'h40, 32'h40};
    tv[11] = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h40};
    tv[12] = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h40};

    repeat (2) tick();
    rst = 1'b0;

    // Single fetch at 0x42: linear and wrap orders, latency and line contents.
    req  = 1'b1;
    addr = 32'h42;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) begin
        tick();
        req = 1'b0;
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("table%0d gnt T%0d", m, i), 128'(gnt[m]), 128'(tv[i].gnt));
        chk($sformatf("table%0d busy T%0d", m, i), 128'(busy[m]), 128'(tv[i].busy));
        chk($sformatf("table%0d rsp T%0d", m, i), 128'(rsp[m]), 128'(tv[i].rsp));
        if (tv[i].rsp) chk($sformatf("table%0d line T%0d", m, i), data[m], LINE40);
      end
      chk($sformatf("table lin rom_addr T%0d", i), 128'(rom_addr[0]), 128'(tv[i].ra_lin));
      chk($sformatf("table wrap rom_addr T%0d", i), 128'(rom_addr[1]), 128'(tv[i].ra_wrap));
    end

    // Reset held three cycles with a pending request: everything reads zero.
    tick();
    rst  = 1'b1;
    req  = 1'b1;
    addr = 32'h123;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("reset%0d gnt c%0d", m, i), 128'(gnt[m]), 128'(1'b0));
        chk($sformatf("reset%0d busy c%0d", m, i), 128'(busy[m]), 128'(1'b0));
        chk($sformatf("reset%0d rsp c%0d", m, i), 128'(rsp[m]), 128'(1'b0));
        chk($sformatf("reset%0d data c%0d", m, i), data[m], 128'(0));
        chk($sformatf("reset%0d rom_addr c%0d", m, i), 128'(rom_addr[m]), 128'(0));
      end
      tick();
    end
    rst = 1'b0;
    req = 1'b0;

    // Back-to-back with the request held: grants at T0 and T11 only.
    req  = 1'b1;
    addr = 32'h40;
    for (int i = 0; i < 22; i++) begin
      if (i > 0) begin
        tick();
        if (i == 1) addr = 32'h80;
      end
      @(negedge clk);
      chk($sformatf("b2b gnt T%0d", i), 128'(gnt[0]), 128'(i == 0 || i == 11));
      chk($sformatf("b2b rsp T%0d", i), 128'(rsp[0]), 128'(i == 10 || i == 21));
      if (i == 10 || i == 11) chk($sformatf("b2b first line T%0d", i), data[0], LINE40);
      if (i == 21) chk("b2b second slot0", 128'(data[0][31:0]), 128'(32'hA5A50080));
    end
    tick();
    req = 1'b0;

    // Reset during the fill aborts the transaction and clears the line.
    tick();
    req  = 1'b1;
    addr = 32'h40;
    @(negedge clk);
    chk("midfill gnt", 128'(gnt[0]), 128'(1'b1));
    tick();
    req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midfill busy", 128'(busy[0]), 128'(1'b0));
    chk("midfill data", data[0], 128'(0));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("midfill no rsp c%0d", i), 128'(rsp[0]), 128'(1'b0));
      tick();
    end
    req = 1'b1;
    @(negedge clk);
    chk("rerun gnt", 128'(gnt[0]), 128'(1'b1));
    for (n = 1; n <= 20; n++) begin
      tick();
      req = 1'b0;
      @(negedge clk);
      if (rsp[0]) break;
    end
    chk("rerun latency", 128'(n), 128'(MD));
    chk("rerun line", data[0], LINE40);
    tick();

    // Random traffic with occasional resets, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      tick();
      req  = ($urandom_range(3) != 0);
      addr = $urandom;
      rst  = ($urandom_range(299) == 0);
    end
    tick();
    rst = 1'b0;
    req = 1'b0;
    repeat (15) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
